// File: rtl/sha_miner_pkg.sv
// Shared definitions for the SHA-256 mining front end.
// Holds the nonce loader FSM state encoding and the message layout constants
// used by the loader and by the top level that pairs it with the hasher.
package sha_miner_pkg;

  // Message layout of the hasher input block.
  localparam int MSG_WORDS        = 20;
  localparam int HASH_WORDS       = 8;

  // Default header template size and nonce position inside the message.
  localparam int DEF_HDR_WORDS    = 19;
  localparam int DEF_NONCE_OFFSET = 19;

  typedef enum logic [3:0] {
    IDLE,
    COPY_RD,
    COPY_WR,
    WR_NONCE,
    HSTART,
    HLAUNCH,
    HWAIT,
    RD_H0,
    CHK
  } state_t;

endpackage

// File: rtl/sha256_nonce_loader.sv
// Nonce loader / search controller in front of simplified_sha256.
// Copies the header template into the hasher message area once, then for
// every nonce in the requested range writes the nonce word, launches the
// hasher, waits for it, reads h0 back and compares it against the target.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin a search (sampled only while idle)
//   header_addr           word address of the header template
//   message_addr          word address of the hasher message area
//   output_addr           word address where the hasher leaves h0
//   nonce_start/count     first nonce and number of nonces to try
//   target                success when h0 < target (unsigned)
//   hash_done/hash_start  hasher handshake (done level / start pulse)
//   mem_*                 shared single-port memory; mem_sel=1 means we own it
//   done                  high while idle
//   found/found_nonce/found_hash0  result of the last search
module sha256_nonce_loader
  import sha_miner_pkg::*;
#(
  parameter int HDR_WORDS    = DEF_HDR_WORDS,
  parameter int NONCE_OFFSET = DEF_NONCE_OFFSET
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] header_addr,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] nonce_start,
  input  logic [15:0] nonce_count,
  input  logic [31:0] target,
  input  logic        hash_done,
  output logic        hash_start,
  output logic        mem_clk,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic [31:0] found_hash0
);

  localparam logic [15:0] LAST_K  = 16'(HDR_WORDS - 1);
  localparam logic [15:0] NONCE_W = 16'(NONCE_OFFSET);

  state_t      state, state_next;
  logic [15:0] k;
  logic [15:0] iter;
  logic [31:0] nonce;
  logic [15:0] hdr_base;
  logic [15:0] msg_base;
  logic [15:0] out_base;
  logic [15:0] count;
  logic [31:0] target_lat;

  logic        hit;
  logic        last_iter;

  assign mem_clk   = clk;
  assign hit       = (mem_read_data < target_lat);
  assign last_iter = (iter == count - 16'd1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (start) state_next = (nonce_count == 16'd0) ? IDLE : COPY_RD;
      COPY_RD:  state_next = COPY_WR;
      COPY_WR:  state_next = (k == LAST_K) ? WR_NONCE : COPY_RD;
      WR_NONCE: state_next = HSTART;
      HSTART:   state_next = HLAUNCH;
      // Dead cycle: gives the hasher time to drop hash_done after the start.
      HLAUNCH:  state_next = HWAIT;
      HWAIT:    if (hash_done) state_next = RD_H0;
      RD_H0:    state_next = CHK;
      CHK: begin
        if (hit || last_iter) state_next = IDLE;
        else                  state_next = WR_NONCE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state; idle values double as reset values.
  always_comb begin
    done           = 1'b0;
    hash_start     = 1'b0;
    mem_sel        = 1'b1;
    mem_we         = 1'b0;
    mem_addr       = 16'd0;
    mem_write_data = 32'd0;
    unique case (state)
      IDLE:     done = 1'b1;
      COPY_RD:  mem_addr = header_addr_k();
      COPY_WR: begin
        mem_addr       = msg_base + k;
        mem_we         = 1'b1;
        mem_write_data = mem_read_data;
      end
      WR_NONCE: begin
        mem_addr       = msg_base + NONCE_W;
        mem_we         = 1'b1;
        mem_write_data = nonce;
      end
      HSTART: begin
        hash_start = 1'b1;
        mem_sel    = 1'b0;
      end
      HLAUNCH:  mem_sel  = 1'b0;
      HWAIT:    mem_sel  = 1'b0;
      RD_H0:    mem_addr = out_base;
      CHK:      ;
      default:  ;
    endcase
  end

  function automatic logic [15:0] header_addr_k();
    return hdr_base + k;
  endfunction

  // Counters, latched search parameters and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k           <= 16'd0;
      iter        <= 16'd0;
      nonce       <= 32'd0;
      hdr_base    <= 16'd0;
      msg_base    <= 16'd0;
      out_base    <= 16'd0;
      count       <= 16'd0;
      target_lat  <= 32'd0;
      found       <= 1'b0;
      found_nonce <= 32'd0;
      found_hash0 <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            hdr_base    <= header_addr;
            msg_base    <= message_addr;
            out_base    <= output_addr;
            count       <= nonce_count;
            target_lat  <= target;
            nonce       <= nonce_start;
            k           <= 16'd0;
            iter        <= 16'd0;
            found       <= 1'b0;
            found_nonce <= 32'd0;
            found_hash0 <= 32'd0;
          end
        end
        COPY_WR: k <= k + 16'd1;
        CHK: begin
          if (hit) begin
            found       <= 1'b1;
            found_nonce <= nonce;
            found_hash0 <= mem_read_data;
          end else if (!last_iter) begin
            nonce <= nonce + 32'd1;
            iter  <= iter + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
